// File: rtl/i2s_pcm_tx.sv
// ---------------------------------------------------------------------------
// i2s_pcm_tx
//   PCM-to-I2S transmitter. Parallel PCM samples are queued in a two-entry
//   FIFO and serialised onto SD in Philips I2S format. This block is the bus
//   master: it generates SCK and WS itself.
//
//   Parameters
//     CLK_DIV  clk cycles per SCK period (even, >= 2)
//     DATA_W   sample width, sent MSB first
//     SLOT_W   SCK bits per channel slot (>= DATA_W+1), frame = 2*SLOT_W bits
//
//   Ports
//     clk       system clock, all logic on posedge
//     rst       synchronous reset, active-high
//     in_valid  sample offered
//     in_ready  block can accept a sample
//     in_ch     channel tag of the offered sample (0 = left, 1 = right)
//     in_data   PCM sample
//     i2s_sck   serial bit clock, clk/CLK_DIV, 50% duty
//     i2s_ws    word select (0 = left slot, 1 = right slot)
//     i2s_sd    serial data
//     underrun  1-clk pulse: a slot started with the FIFO empty
//     ch_err    1-clk pulse: a slot started with a wrong-channel FIFO head
//
//   Handshake: a sample transfers on every posedge where in_valid && in_ready.
//   in_ready comes only from the registered FIFO count, so it never depends
//   on in_valid in the same cycle. The sender keeps in_valid, in_ch and
//   in_data stable until the transfer happens.
// ---------------------------------------------------------------------------
module i2s_pcm_tx #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              i2s_sck,
  output logic              i2s_ws,
  output logic              i2s_sd,
  output logic              underrun,
  output logic              ch_err
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(SLOT_W);

  typedef struct packed {
    logic              ch;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Divider and frame position
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_nxt;
  logic              tick;
  logic              slot_start;
  logic              exp_ch;

  // Serialiser
  logic [DATA_W-1:0] shreg;

  // FIFO
  entry_t            fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  entry_t            head;
  logic              head_valid;
  logic              push;
  logic              pop;
  logic              ch_match;

  // -------------------------------------------------------------------------
  // Combinational control
  // -------------------------------------------------------------------------
  always_comb begin
    tick       = (div_cnt == DIV_LAST);
    div_nxt    = tick ? '0 : div_cnt + 1'b1;
    bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    // A slot starts on the tick that moves the frame to bit 0 (left) or to
    // SLOT_W (right); the expected channel follows from which one it is.
    slot_start = tick && ((bit_nxt == '0) || (bit_nxt == BIT_RIGHT));
    exp_ch     = (bit_nxt == BIT_RIGHT);
    head       = fifo_mem[rd_ptr];
    head_valid = (count != 2'd0);
    ch_match   = (head.ch == exp_ch);
    // A wrong-channel head is still popped so the stream resynchronises.
    pop        = slot_start && head_valid;
    push       = in_valid && in_ready;
  end

  assign in_ready = (count < 2'd2);

  // -------------------------------------------------------------------------
  // Clock divider, frame counter, serialiser, status pulses, FIFO pointers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      i2s_sck  <= 1'b0;
      bit_cnt  <= BIT_LAST;
      i2s_ws   <= 1'b1;
      i2s_sd   <= 1'b0;
      shreg    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      underrun <= 1'b0;
      ch_err   <= 1'b0;
    end else begin
      div_cnt  <= div_nxt;
      // Registered so SCK is glitch-free; the update on the tick edge is the
      // SCK falling edge, which is when WS and SD change.
      i2s_sck  <= (div_nxt >= DIV_HALF);
      underrun <= slot_start && !head_valid;
      ch_err   <= pop && !ch_match;

      if (tick) begin
        bit_cnt <= bit_nxt;
        i2s_ws  <= (bit_nxt >= BIT_RIGHT);
        if (slot_start) begin
          // Slot bit 0 is always 0: the MSB goes out one SCK after the WS edge.
          i2s_sd <= 1'b0;
          shreg  <= (pop && ch_match) ? head.data : '0;
        end else begin
          // Zeros shift in behind the sample, giving the trailing pad bits.
          i2s_sd <= shreg[DATA_W-1];
          shreg  <= {shreg[DATA_W-2:0], 1'b0};
        end
      end

      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;

      // Simultaneous push and pop leaves the count unchanged; the pop reads
      // the entry at rd_ptr, which the push (at wr_ptr) cannot overwrite.
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{ch: in_ch, data: in_data};
  end

endmodule

// File: tb/tb_i2s_pcm_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_pcm_tx
//   Directed bench for i2s_pcm_tx (CLK_DIV=4, DATA_W=24, SLOT_W=32).
//   A negedge monitor decodes the I2S stream like a receiver would (sampling
//   SD on SCK rising edges, aligning on WS edges) and collects {ch,data}
//   words; each test compares them against hand-written expected words.
// ---------------------------------------------------------------------------
module tb_i2s_pcm_tx;

  localparam int CLK_DIV = 4;
  localparam int DATA_W  = 24;
  localparam int SLOT_W  = 32;
  localparam int W       = DATA_W + 1;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT
  logic              in_valid;
  logic              in_ready;
  logic              in_ch;
  logic [DATA_W-1:0] in_data;
  logic              i2s_sck;
  logic              i2s_ws;
  logic              i2s_sd;
  logic              underrun;
  logic              ch_err;

  i2s_pcm_tx #(
    .CLK_DIV(CLK_DIV),
    .DATA_W (DATA_W),
    .SLOT_W (SLOT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ch   (in_ch),
    .in_data (in_data),
    .i2s_sck (i2s_sck),
    .i2s_ws  (i2s_ws),
    .i2s_sd  (i2s_sd),
    .underrun(underrun),
    .ch_err  (ch_err)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int rst_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Upstream contract: while stalled, the offered sample must not change.
  logic              hold_pend = 1'b0;
  logic              hold_ch;
  logic [DATA_W-1:0] hold_data;
  always @(posedge clk) begin
    if (hold_pend)
      assert (in_valid && in_ch == hold_ch && in_data == hold_data)
        else $error("upstream hold violated");
    hold_pend <= in_valid && !in_ready && !rst;
    hold_ch   <= in_ch;
    hold_data <= in_data;
  end

  // Monitor / receiver model (cleared whenever rst is driven)
  int und_cnt, err_cnt, sd_ones, nready_cnt, pad_err;
  int und_first, und_last, err_cyc, ws_fall_cyc, ws_rise_cyc, rx_idx;
  logic prev_sck, prev_ws, rx_prev_ws;
  logic [DATA_W-1:0] rx_sh;

  always @(negedge clk) begin
    if (rst) begin
      und_cnt = 0; err_cnt = 0; sd_ones = 0; nready_cnt = 0; pad_err = 0;
      und_first = -1; und_last = -1; err_cyc = -1;
      ws_fall_cyc = -1; ws_rise_cyc = -1;
      rx_idx = 63; rx_prev_ws = 1'b1; prev_ws = 1'b1; prev_sck = 1'b0;
      rx_sh = '0;
      rx_q.delete();
    end else begin
      if (underrun) begin
        und_cnt++;
        if (und_first < 0) und_first = cyc;
        und_last = cyc;
      end
      if (ch_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (i2s_sd) sd_ones++;
      if (!in_ready) nready_cnt++;
      if (i2s_ws != prev_ws) begin
        if (!i2s_ws) ws_fall_cyc = cyc;
        else         ws_rise_cyc = cyc;
      end
      prev_ws = i2s_ws;
      if (i2s_sck && !prev_sck) begin
        if (i2s_ws != rx_prev_ws) rx_idx = 0;
        else if (rx_idx < 63)     rx_idx++;
        rx_prev_ws = i2s_ws;
        if (rx_idx >= 1 && rx_idx <= DATA_W) rx_sh = {rx_sh[DATA_W-2:0], i2s_sd};
        else if (rx_idx < SLOT_W && i2s_sd)  pad_err++;
        if (rx_idx == DATA_W) rx_q.push_back({i2s_ws, rx_sh});
      end
      prev_sck = i2s_sck;
    end
  end

  // Driver tasks (called away from the active edge)
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst_cyc = cyc;
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic ch, input logic [DATA_W-1:0] d, output int acc);
    int w;
    in_valid = 1'b1;
    in_ch    = ch;
    in_data  = d;
    w = 0;
    while (!in_ready && w < 2000) begin @(posedge clk); #1; w++; end
    if (!in_ready) check("push_ready_timeout", in_ready, 1);
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_words(input int n, input int bound);
    int w;
    w = 0;
    while (rx_q.size() < n && w < bound) begin @(posedge clk); #1; w++; end
  endtask

  task automatic check_words(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sck"},      i2s_sck,  0);
    check({tag, "_ws"},       i2s_ws,   1);
    check({tag, "_sd"},       i2s_sd,   0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_ch_err"},   ch_err,   0);
  endtask

  initial begin
    int a0, a1, a2, base;
    rst = 1'b1; in_valid = 1'b0; in_ch = 1'b0; in_data = '0;

    // 1: one left and one right sample
    do_reset();
    check_reset_state("t1_rst");
    push(1'b0, 24'hABCDEF, a0);
    push(1'b1, 24'h123456, a1);
    exp_q.delete();
    exp_q.push_back({1'b0, 24'hABCDEF});
    exp_q.push_back({1'b1, 24'h123456});
    wait_words(2, 800);
    check_words("t1");
    check("t1_ws_low_clks", ws_rise_cyc - ws_fall_cyc, 128);
    check("t1_pad_bits",    pad_err, 0);
    check("t1_underruns",   und_cnt, 0);

    // 2: no samples for two frames
    do_reset();
    wait_until(rst_cyc + 512);
    check("t2_underruns",   und_cnt, 4);
    check("t2_und_span",    und_last - und_first, 384);
    check("t2_first_und",   und_first - rst_cyc, 4);
    check("t2_ch_errs",     err_cnt, 0);
    check("t2_sd_ones",     sd_ones, 0);
    check("t2_not_ready",   nready_cnt, 0);

    // 3: right sample arrives before a left slot
    do_reset();
    push(1'b1, 24'h000001, a0);
    push(1'b1, 24'h000002, a1);
    exp_q.delete();
    exp_q.push_back({1'b0, 24'h000000});
    exp_q.push_back({1'b1, 24'h000002});
    wait_words(2, 800);
    check_words("t3");
    check("t3_ch_errs",   err_cnt, 1);
    check("t3_err_cyc",   err_cyc - rst_cyc, 4);
    check("t3_underruns", und_cnt, 0);

    // 4: three samples back-to-back against a two-entry FIFO
    do_reset();
    push(1'b0, 24'h111111, a0);
    push(1'b1, 24'h222222, a1);
    push(1'b0, 24'h333333, a2);
    check("t4_acc0", a0 - rst_cyc, 1);
    check("t4_acc1", a1 - rst_cyc, 2);
    check("t4_acc2", a2 - rst_cyc, 5);
    exp_q.delete();
    exp_q.push_back({1'b0, 24'h111111});
    exp_q.push_back({1'b1, 24'h222222});
    exp_q.push_back({1'b0, 24'h333333});
    exp_q.push_back({1'b1, 24'h000000});
    wait_words(4, 1200);
    check_words("t4");
    check("t4_underruns", und_cnt, 1);

    // 5: reset in the middle of a right slot, with a sample still queued
    do_reset();
    base = rst_cyc;
    push(1'b0, 24'hFFFFFF, a0);
    push(1'b1, 24'hFFFFFF, a1);
    wait_until(base + 140);
    push(1'b0, 24'h5A5A5A, a2);
    wait_until(base + 165);
    check("t5_pre_ws", i2s_ws, 1);
    check("t5_pre_sd", i2s_sd, 1);
    do_reset();
    check_reset_state("t5_rst");
    wait_cyc(3);
    check("t5_no_tick_ws",  i2s_ws,   1);
    check("t5_no_tick_und", underrun, 0);
    wait_cyc(1);
    check("t5_tick_ws",     i2s_ws,   0);
    check("t5_tick_und",    underrun, 1);

    // 6: full-scale alternating samples over four frames
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      logic [DATA_W-1:0] d;
      d = i[0] ? 24'h7FFFFF : 24'h800000;
      exp_q.push_back({i[0], d});
      push(i[0], d, a0);
    end
    wait_words(8, 1500);
    check_words("t6");
    check("t6_underruns", und_cnt, 0);
    check("t6_ch_errs",   err_cnt, 0);
    check("t6_pad_bits",  pad_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
